// File: rtl/ecc_sed_pkg.sv
// Shared definitions for the single-error-detect (SED) encoder/checker pair.
// Holds the codeword geometry and the parity function both sides agree on.
package ecc_sed_pkg;

  localparam int DATA_W     = 12;
  localparam int CW_W       = DATA_W + 1;
  localparam int PARITY_BIT = DATA_W;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // Parity bit that makes the whole codeword XOR to 'odd'.
  function automatic logic sed_parity(input logic [DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/ecc_sed_checker_if.sv
// Codeword input, result output and status bundle of the SED checker.
// The master side feeds codewords and consumes results; the checker is the slave.
interface ecc_sed_checker_if #(
  parameter int DATA_W = ecc_sed_pkg::DATA_W,
  parameter int CNT_W  = 8
);

  logic              enc_valid;
  logic [DATA_W:0]   enc_codeword;
  logic              in_ready;
  logic              dec_valid;
  logic [DATA_W-1:0] dec_data;
  logic              dec_err;
  logic              out_ready;
  logic              err_clr;
  logic              err_sticky;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output enc_valid, enc_codeword, out_ready, err_clr,
    input  in_ready, dec_valid, dec_data, dec_err, err_sticky, err_count
  );

  modport slave (
    input  enc_valid, enc_codeword, out_ready, err_clr,
    output in_ready, dec_valid, dec_data, dec_err, err_sticky, err_count
  );

endinterface

// File: rtl/ecc_sed_syndrome.sv
// Combinational parity syndrome: 1 when the codeword weight disagrees with
// the configured parity sense.
module ecc_sed_syndrome #(
  parameter int CW_W       = ecc_sed_pkg::CW_W,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic [CW_W-1:0] codeword,
  output logic            syndrome
);

  assign syndrome = (^codeword) ^ PARITY_ODD;

endmodule

// File: rtl/ecc_sed_checker.sv
// SED checker: checks parity of each accepted codeword, returns the payload
// through a one-entry registered output stage and keeps error status.
module ecc_sed_checker #(
  parameter int DATA_W     = ecc_sed_pkg::DATA_W,
  parameter int CNT_W      = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input logic               clk,
  input logic               rst,
  ecc_sed_checker_if.slave  bus
);

  import ecc_sed_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  out_state_t        state_q;
  out_state_t        state_d;
  logic              syndrome;
  logic              in_ready;
  logic              accept;
  logic [DATA_W-1:0] data_q;
  logic              err_q;
  logic              sticky_q;
  logic [CNT_W-1:0]  count_q;

  ecc_sed_syndrome #(
    .CW_W       (DATA_W + 1),
    .PARITY_ODD (PARITY_ODD)
  ) u_syndrome (
    .codeword (bus.enc_codeword),
    .syndrome (syndrome)
  );

  // The slot frees up in the same cycle the consumer drains it.
  assign in_ready = (state_q == OUT_EMPTY) | bus.out_ready;
  assign accept   = bus.enc_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= OUT_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (accept) state_d = OUT_FULL;
      OUT_FULL:  if (bus.out_ready && !accept) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  always_comb begin
    bus.in_ready   = in_ready;
    bus.dec_valid  = (state_q == OUT_FULL);
    bus.dec_data   = data_q;
    bus.dec_err    = err_q;
    bus.err_sticky = sticky_q;
    bus.err_count  = count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      data_q <= bus.enc_codeword[DATA_W-1:0];
      err_q  <= syndrome;
    end
  end

  // A clear coinciding with an errored accept leaves exactly that one error counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else if (accept && syndrome) begin
      sticky_q <= 1'b1;
      if (bus.err_clr)            count_q <= CNT_W'(1);
      else if (count_q != CNT_MAX) count_q <= count_q + CNT_W'(1);
    end else if (bus.err_clr) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end
  end

endmodule

// File: tb/tb_ecc_sed_checker.sv
// Randomized self-checking bench: an even- and an odd-parity checker see the
// same traffic and are compared against a popcount-based reference model.
module tb_ecc_sed_checker;

  import ecc_sed_pkg::*;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // Reference state, index = parity sense of the checker (0 even, 1 odd)
  logic              m_valid [2];
  logic [DATA_W-1:0] m_data  [2];
  logic              m_err   [2];
  logic              m_sticky[2];
  int                m_count [2];

  ecc_sed_checker_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus0 ();
  ecc_sed_checker_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus1 ();

  ecc_sed_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W), .PARITY_ODD(1'b0)) dut_even (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  ecc_sed_checker #(.DATA_W(DATA_W), .CNT_W(CNT_W), .PARITY_ODD(1'b1)) dut_odd (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [DATA_W:0] makeWord(input logic [DATA_W-1:0] d, input logic odd,
                                               input logic corrupt);
    logic [DATA_W:0] w;
    w = {1'b0, d};
    w[PARITY_BIT] = sed_parity(d, odd) ^ corrupt;
    return w;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      m_valid[k]  = 1'b0;
      m_data[k]   = '0;
      m_err[k]    = 1'b0;
      m_sticky[k] = 1'b0;
      m_count[k]  = 0;
    end
  endtask

  task automatic checkDut(input int k, input logic v, input logic [DATA_W-1:0] d, input logic e,
                          input logic st, input logic [CNT_W-1:0] c);
    string sfx;
    sfx = (k == 0) ? "even" : "odd";
    checkOutput({"dec_valid_", sfx}, 32'(v), 32'(m_valid[k]));
    if (m_valid[k]) begin
      checkOutput({"dec_data_", sfx}, 32'(d), 32'(m_data[k]));
      checkOutput({"dec_err_", sfx}, 32'(e), 32'(m_err[k]));
    end
    checkOutput({"err_sticky_", sfx}, 32'(st), 32'(m_sticky[k]));
    checkOutput({"err_count_", sfx}, 32'(c), 32'(m_count[k]));
  endtask

  task automatic checkBoth();
    checkDut(0, bus0.dec_valid, bus0.dec_data, bus0.dec_err, bus0.err_sticky, bus0.err_count);
    checkDut(1, bus1.dec_valid, bus1.dec_data, bus1.dec_err, bus1.err_sticky, bus1.err_count);
  endtask

  // One clock of traffic: drive, check readiness, advance the model, check results.
  task automatic applyStimulus(input logic v, input logic [DATA_W:0] cw, input logic ordy,
                               input logic clr);
    logic exp_ready;
    logic acc;
    logic s;
    bus0.enc_valid = v;    bus1.enc_valid = v;
    bus0.enc_codeword = cw; bus1.enc_codeword = cw;
    bus0.out_ready = ordy; bus1.out_ready = ordy;
    bus0.err_clr = clr;    bus1.err_clr = clr;
    #1;
    checkOutput("in_ready_even", 32'(bus0.in_ready), 32'(!m_valid[0] || ordy));
    checkOutput("in_ready_odd",  32'(bus1.in_ready), 32'(!m_valid[1] || ordy));
    for (int k = 0; k < 2; k++) begin
      exp_ready = !m_valid[k] || ordy;
      acc = v && exp_ready;
      s = (($countones(cw) % 2) != k);
      if (acc) begin
        m_valid[k] = 1'b1;
        m_data[k]  = cw[DATA_W-1:0];
        m_err[k]   = s;
      end else if (ordy) begin
        m_valid[k] = 1'b0;
      end
      if (clr) begin
        m_count[k]  = 0;
        m_sticky[k] = 1'b0;
      end
      if (acc && s) begin
        m_sticky[k] = 1'b1;
        if (m_count[k] < CNT_MAX) m_count[k]++;
      end
    end
    @(posedge clk);
    #1;
    checkBoth();
  endtask

  initial begin
    logic [DATA_W:0] w;
    logic [DATA_W:0] held;
    rst = 1'b1;
    bus0.enc_valid = 1'b0; bus1.enc_valid = 1'b0;
    bus0.enc_codeword = '0; bus1.enc_codeword = '0;
    bus0.out_ready = 1'b0; bus1.out_ready = 1'b0;
    bus0.err_clr = 1'b0;   bus1.err_clr = 1'b0;
    modelReset();
    #2;
    checkOutput("rst_in_ready_even", 32'(bus0.in_ready), 32'd1);
    checkOutput("rst_in_ready_odd",  32'(bus1.in_ready), 32'd1);
    checkOutput("rst_dec_data_even", 32'(bus0.dec_data), 32'd0);
    checkOutput("rst_dec_err_odd",   32'(bus1.dec_err), 32'd0);
    checkBoth();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic traffic, both parity senses
    applyStimulus(1'b1, 13'h0A5A, 1'b1, 1'b0);
    checkOutput("t1_data", 32'(bus0.dec_data), 32'h0A5A);
    checkOutput("t1_err_even", 32'(bus0.dec_err), 32'd0);
    checkOutput("t1_err_odd", 32'(bus1.dec_err), 32'd1);
    applyStimulus(1'b1, 13'h1A5A, 1'b1, 1'b0);
    checkOutput("t2_err_even", 32'(bus0.dec_err), 32'd1);
    checkOutput("t2_cnt_even", 32'(bus0.err_count), 32'd1);
    checkOutput("t2_err_odd", 32'(bus1.dec_err), 32'd0);
    applyStimulus(1'b1, 13'h0001, 1'b1, 1'b0);
    checkOutput("t2b_cnt_even", 32'(bus0.err_count), 32'd2);

    // Backpressure: result held, nothing accepted, then drain + accept together
    held = bus0.dec_data;
    for (int i = 0; i < 3; i++) begin
      w = 13'($urandom);
      applyStimulus(1'b1, w, 1'b0, 1'b0);
      checkOutput("bp_hold", 32'(bus0.dec_data), 32'(held[DATA_W-1:0]));
    end
    w = 13'h0777;
    applyStimulus(1'b1, w, 1'b1, 1'b0);
    checkOutput("bp_release", 32'(bus0.dec_data), 32'h0777);
    applyStimulus(1'b0, 13'h0, 1'b1, 1'b0);

    // Saturation of each counter, then clear
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, makeWord(12'($urandom), 1'b0, 1'b1), 1'b1, 1'b0);
    checkOutput("sat_even", 32'(bus0.err_count), 32'(CNT_MAX));
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, makeWord(12'($urandom), 1'b1, 1'b1), 1'b1, 1'b0);
    checkOutput("sat_odd", 32'(bus1.err_count), 32'(CNT_MAX));
    applyStimulus(1'b0, 13'h0, 1'b1, 1'b1);
    checkOutput("clr_even", 32'(bus0.err_count), 32'd0);

    // Clear coinciding with an errored accept
    applyStimulus(1'b1, makeWord(12'h3C1, 1'b0, 1'b1), 1'b1, 1'b0);
    applyStimulus(1'b1, makeWord(12'h3C1, 1'b0, 1'b1), 1'b1, 1'b1);
    checkOutput("clr_err_cnt", 32'(bus0.err_count), 32'd1);
    checkOutput("clr_err_sticky", 32'(bus0.err_sticky), 32'd1);

    // Randomized mixed traffic
    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom), 13'($urandom), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 31) == 0));

    // Asynchronous reset while a result is held
    applyStimulus(1'b1, 13'h1234, 1'b0, 1'b0);
    applyStimulus(1'b1, makeWord(12'h0F0, 1'b0, 1'b1), 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid_even", 32'(bus0.dec_valid), 32'd0);
    checkOutput("arst_valid_odd", 32'(bus1.dec_valid), 32'd0);
    modelReset();
    checkBoth();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 13'h1A5A, 1'b1, 1'b0);
    checkOutput("post_rst_data", 32'(bus1.dec_data), 32'h0A5A);
    checkOutput("post_rst_err_odd", 32'(bus1.dec_err), 32'd0);
    applyStimulus(1'b0, 13'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
